// File: rtl/lcd_text_ctrl.sv
// HD44780-class character LCD controller: self-running power-on init, 8- or 4-bit
// bus, valid/ready character and clear requests, cursor tracking with line re-addressing.
module lcd_text_ctrl #(
   parameter int BUS_4BIT  = 0,
   parameter int COLS      = 16,
   parameter int ROWS      = 2,
   parameter int T_POWERON = 750000,
   parameter int T_SETUP   = 2,
   parameter int T_PULSE   = 12,
   parameter int T_NIBBLE  = 50,
   parameter int T_CMD     = 2000,
   parameter int T_LONG    = 205000,
   parameter int T_CLEAR   = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       init,
   input  logic       req_valid,
   input  logic       req_clear,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       init_done,
   output logic [1:0] cursor_row,
   output logic [5:0] cursor_col,
   output logic [7:0] lcd_db,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw
);

   // state    | meaning
   // OFF      | idle after reset, waiting for init
   // PWR_WAIT | power-on settle delay
   // WAKE1..3 | 0x30 wake-up writes, long wait after each
   // SET4     | single 0x2 nibble switching the panel to 4-bit mode
   // FUNC     | function set (0x38 / 0x28)
   // ENTRY    | entry mode 0x06
   // DISP     | display on, cursor off 0x0C
   // CLR      | clear display during init
   // ADDR     | set DDRAM address to the current row base
   // READY    | accepting requests
   // WRITE    | character data write
   // CLR2     | clear requested by the host

   typedef enum logic [3:0] {
      S_OFF, S_PWR_WAIT, S_WAKE1, S_WAKE2, S_WAKE3, S_SET4, S_FUNC,
      S_ENTRY, S_DISP, S_CLR, S_ADDR, S_READY, S_WRITE, S_CLR2
   } state_t;

   // Byte engine phases, orthogonal to the sequencing state above.
   typedef enum logic [2:0] {P_IDLE, P_SETUP, P_PULSE, P_GAP, P_POST} phase_t;

   function automatic int max_t();
      int m;
      m = T_POWERON;
      if (T_SETUP  > m) m = T_SETUP;
      if (T_PULSE  > m) m = T_PULSE;
      if (T_NIBBLE > m) m = T_NIBBLE;
      if (T_CMD    > m) m = T_CMD;
      if (T_LONG   > m) m = T_LONG;
      if (T_CLEAR  > m) m = T_CLEAR;
      return m;
   endfunction

   localparam int CW   = $clog2(max_t() + 1);
   localparam bit BUS4 = (BUS_4BIT != 0);

   function automatic logic [6:0] row_base(input logic [1:0] r);
      case (r)
         2'd0:    return 7'h00;
         2'd1:    return 7'h40;
         2'd2:    return 7'(COLS);
         default: return 7'(64 + COLS);
      endcase
   endfunction

   state_t        state, state_nxt, tgt;
   phase_t        phase, phase_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] post_q, post_nxt;
   logic [7:0]    byte_q, byte_nxt;
   logic [7:0]    db_nxt;
   logic          rs_nxt;
   logic          nib_only_q, nib_only_nxt;
   logic          lo_q, lo_nxt;
   logic [1:0]    row_q, row_nxt;
   logic [5:0]    col_q, col_nxt;
   logic          done_q, done_nxt;
   logic          launch, cnt_tc, wrap;
   logic [6:0]    col_inc;

   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      cnt_nxt      = cnt;
      post_nxt     = post_q;
      byte_nxt     = byte_q;
      db_nxt       = lcd_db;
      rs_nxt       = lcd_rs;
      nib_only_nxt = nib_only_q;
      lo_nxt       = lo_q;
      row_nxt      = row_q;
      col_nxt      = col_q;
      launch       = 1'b0;
      tgt          = state;
      cnt_tc       = (cnt == '0);
      col_inc      = {1'b0, col_q} + 7'd1;
      wrap         = (col_inc == 7'(COLS));

      case (phase)
         P_IDLE: begin
            case (state)
               S_OFF: begin
                  if (init) begin
                     state_nxt = S_PWR_WAIT;
                     cnt_nxt   = CW'(T_POWERON - 1);
                  end
               end
               S_PWR_WAIT: begin
                  if (cnt_tc) begin
                     launch = 1'b1;
                     tgt    = S_WAKE1;
                  end else begin
                     cnt_nxt = cnt - CW'(1);
                  end
               end
               S_READY: begin
                  if (req_valid) begin
                     launch = 1'b1;
                     if (req_clear) begin
                        tgt     = S_CLR2;
                        row_nxt = 2'd0;
                        col_nxt = 6'd0;
                     end else begin
                        tgt = S_WRITE;
                     end
                  end
               end
               default: ;
            endcase
         end
         P_SETUP: begin
            if (cnt_tc) begin
               phase_nxt = P_PULSE;
               cnt_nxt   = CW'(T_PULSE - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         P_PULSE: begin
            if (cnt_tc) begin
               if (BUS4 && !nib_only_q && !lo_q) begin
                  phase_nxt = P_GAP;
                  cnt_nxt   = CW'(T_NIBBLE - 1);
               end else begin
                  phase_nxt = P_POST;
                  cnt_nxt   = post_q;
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         P_GAP: begin
            if (cnt_tc) begin
               db_nxt    = {byte_q[3:0], 4'h0};
               lo_nxt    = 1'b1;
               phase_nxt = P_SETUP;
               cnt_nxt   = CW'(T_SETUP - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         P_POST: begin
            if (cnt_tc) begin
               phase_nxt = P_IDLE;
               launch    = 1'b1;
               case (state)
                  S_WAKE1: tgt = S_WAKE2;
                  S_WAKE2: tgt = S_WAKE3;
                  S_WAKE3: begin
                     if (BUS4) tgt = S_SET4;
                     else      tgt = S_FUNC;
                  end
                  S_SET4:        tgt = S_FUNC;
                  S_FUNC:        tgt = S_ENTRY;
                  S_ENTRY:       tgt = S_DISP;
                  S_DISP:        tgt = S_CLR;
                  S_CLR, S_CLR2: tgt = S_ADDR;
                  S_WRITE: begin
                     if (wrap) begin
                        col_nxt = 6'd0;
                        row_nxt = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
                        tgt     = S_ADDR;
                     end else begin
                        col_nxt   = col_inc[5:0];
                        launch    = 1'b0;
                        state_nxt = S_READY;
                     end
                  end
                  default: begin
                     launch    = 1'b0;
                     state_nxt = S_READY;
                  end
               endcase
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: phase_nxt = P_IDLE;
      endcase

      // Starting a byte latches it onto the bus in the same edge as the state change.
      if (launch) begin
         state_nxt    = tgt;
         phase_nxt    = P_SETUP;
         cnt_nxt      = CW'(T_SETUP - 1);
         lo_nxt       = 1'b0;
         rs_nxt       = 1'b0;
         nib_only_nxt = 1'b0;
         post_nxt     = CW'(T_CMD - 1);
         case (tgt)
            S_WAKE1, S_WAKE2, S_WAKE3: begin
               byte_nxt     = 8'h30;
               nib_only_nxt = 1'b1;
               post_nxt     = CW'(T_LONG - 1);
            end
            S_SET4: begin
               byte_nxt     = 8'h20;
               nib_only_nxt = 1'b1;
            end
            S_FUNC:  byte_nxt = BUS4 ? 8'h28 : 8'h38;
            S_ENTRY: byte_nxt = 8'h06;
            S_DISP:  byte_nxt = 8'h0C;
            S_CLR, S_CLR2: begin
               byte_nxt = 8'h01;
               post_nxt = CW'(T_CLEAR - 1);
            end
            S_ADDR:  byte_nxt = {1'b1, row_base(row_nxt)};
            S_WRITE: begin
               byte_nxt = req_data;
               rs_nxt   = 1'b1;
            end
            default: byte_nxt = byte_q;
         endcase
         db_nxt = BUS4 ? {byte_nxt[7:4], 4'h0} : byte_nxt;
      end

      done_nxt = done_q | (state_nxt == S_READY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_OFF;
         phase      <= P_IDLE;
         cnt        <= '0;
         post_q     <= '0;
         byte_q     <= 8'h00;
         lcd_db     <= 8'h00;
         lcd_rs     <= 1'b0;
         nib_only_q <= 1'b0;
         lo_q       <= 1'b0;
         row_q      <= 2'd0;
         col_q      <= 6'd0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         cnt        <= cnt_nxt;
         post_q     <= post_nxt;
         byte_q     <= byte_nxt;
         lcd_db     <= db_nxt;
         lcd_rs     <= rs_nxt;
         nib_only_q <= nib_only_nxt;
         lo_q       <= lo_nxt;
         row_q      <= row_nxt;
         col_q      <= col_nxt;
         done_q     <= done_nxt;
      end
   end

   assign req_ready  = (state == S_READY);
   assign init_done  = done_q;
   assign lcd_e      = (phase == P_PULSE);
   assign lcd_rw     = 1'b0;
   assign cursor_row = row_q;
   assign cursor_col = col_q;

endmodule
